// File: rtl/uart_fd.sv
// ============================================================================
// uart_fd -- parametrised full-duplex UART
//
// Independent transmit and receive engines sharing only the clock and reset.
// Frame format: one start bit (low), DATA_BITS payload bits LSB first, an
// optional parity bit, then STOP_BITS stop bits (high).
//
// Parameters
//   CLK_HZ     system clock frequency in Hz
//   BAUD       line rate; CLKS_PER_BIT = CLK_HZ / BAUD (integer divide, >= 2)
//   DATA_BITS  payload bits per frame, 5..9
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  transmitted stop bits, 1..2 (receiver checks the first only)
//
// Ports
//   clk            system clock, all logic on the rising edge
//   rst_n          synchronous reset, active low
//   rx             serial input, asynchronous to clk
//   tx             serial output, idles high
//   tx_data        payload to send, captured on the tx_valid/tx_ready handshake
//   tx_valid       transmit request
//   tx_ready       transmitter idle and able to accept a payload
//   rx_data        last received payload, held until the next rx_valid
//   rx_valid       one-cycle pulse: rx_data and the error flags are new
//   rx_parity_err  parity mismatch on the last received frame
//   rx_frame_err   first stop bit sampled low on the last received frame
// ============================================================================
module uart_fd #(
    parameter int CLK_HZ    = 12000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int TIMER_W      = $clog2(CLKS_PER_BIT + 1);

    // Terminal count of a full bit period and of the half-bit start check.
    localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);

    // Bit counters are 4 bits wide: enough for up to 9 payload bits.
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    localparam logic HAS_PARITY = (PARITY != 0);
    // XOR of the payload is the even-parity bit; odd parity inverts it.
    localparam logic ODD_PARITY = (PARITY == 1);

    // ------------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    tx_state_t            tx_state;
    logic [TIMER_W-1:0]   tx_timer;
    logic [3:0]           tx_bit_cnt;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par_bit;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the values from before the edge.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset along with control so that a
        // mid-frame reset leaves no stale payload behind.
        if (!rst_n) begin
            tx_state   <= TX_IDLE;
            tx         <= 1'b1;
            tx_ready   <= 1'b0;
            tx_timer   <= '0;
            tx_bit_cnt <= '0;
            tx_shift   <= '0;
            tx_par_bit <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_timer   <= '0;
                    tx_bit_cnt <= '0;
                    if (tx_valid && tx_ready) begin
                        // Start bit goes out on the accept edge itself.
                        tx_shift   <= tx_data;
                        tx_par_bit <= (^tx_data) ^ ODD_PARITY;
                        tx         <= 1'b0;
                        tx_ready   <= 1'b0;
                        tx_state   <= TX_START;
                    end else begin
                        tx       <= 1'b1;
                        tx_ready <= 1'b1;
                    end
                end

                TX_START: begin
                    if (tx_timer == BIT_LAST) begin
                        tx_timer <= '0;
                        tx       <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_timer <= tx_timer + 1'b1;
                    end
                end

                TX_DATA: begin
                    if (tx_timer == BIT_LAST) begin
                        tx_timer <= '0;
                        if (tx_bit_cnt == DATA_LAST) begin
                            tx_bit_cnt <= '0;
                            if (HAS_PARITY) begin
                                tx       <= tx_par_bit;
                                tx_state <= TX_PARITY;
                            end else begin
                                tx       <= 1'b1;
                                tx_state <= TX_STOP;
                            end
                        end else begin
                            // Bit 1 of the current shift value is the next
                            // bit on the line once the register shifts.
                            tx_bit_cnt <= tx_bit_cnt + 1'b1;
                            tx_shift   <= tx_shift >> 1;
                            tx         <= tx_shift[1];
                        end
                    end else begin
                        tx_timer <= tx_timer + 1'b1;
                    end
                end

                TX_PARITY: begin
                    if (tx_timer == BIT_LAST) begin
                        tx_timer <= '0;
                        tx       <= 1'b1;
                        tx_state <= TX_STOP;
                    end else begin
                        tx_timer <= tx_timer + 1'b1;
                    end
                end

                TX_STOP: begin
                    tx <= 1'b1;
                    if (tx_timer == BIT_LAST) begin
                        tx_timer <= '0;
                        if (tx_bit_cnt == STOP_LAST) begin
                            // Ready rises as the last stop bit ends; the next
                            // accept is one IDLE cycle later at the earliest.
                            tx_bit_cnt <= '0;
                            tx_ready   <= 1'b1;
                            tx_state   <= TX_IDLE;
                        end else begin
                            tx_bit_cnt <= tx_bit_cnt + 1'b1;
                        end
                    end else begin
                        tx_timer <= tx_timer + 1'b1;
                    end
                end

                default: begin
                    tx       <= 1'b1;
                    tx_ready <= 1'b0;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Receiver input synchroniser
    // ------------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;

    // NOTE: rx is asynchronous; only rx_sync, two flops downstream, may be
    // used by the receive logic. Both flops reset to the idle (high) level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    rx_state_t            rx_state;
    logic [TIMER_W-1:0]   rx_timer;
    logic [3:0]           rx_bit_cnt;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state      <= RX_IDLE;
            rx_timer      <= '0;
            rx_bit_cnt    <= '0;
            rx_shift      <= '0;
            rx_par_bit    <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            // rx_valid is a single-cycle pulse; only the stop sample raises it.
            rx_valid <= 1'b0;

            case (rx_state)
                RX_IDLE: begin
                    rx_timer   <= '0;
                    rx_bit_cnt <= '0;
                    if (!rx_sync) begin
                        rx_state <= RX_START;
                    end
                end

                RX_START: begin
                    // Half a bit in: still low means a real start bit, and the
                    // timer restarts so later samples land on bit centres.
                    if (rx_timer == HALF_LAST) begin
                        rx_timer <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_timer <= rx_timer + 1'b1;
                    end
                end

                RX_DATA: begin
                    if (rx_timer == BIT_LAST) begin
                        rx_timer <= '0;
                        // Shift in from the top so the first (LSB) bit ends
                        // up in bit 0 after DATA_BITS samples.
                        rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit_cnt == DATA_LAST) begin
                            rx_bit_cnt <= '0;
                            rx_state   <= HAS_PARITY ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bit_cnt <= rx_bit_cnt + 1'b1;
                        end
                    end else begin
                        rx_timer <= rx_timer + 1'b1;
                    end
                end

                RX_PARITY: begin
                    if (rx_timer == BIT_LAST) begin
                        rx_timer   <= '0;
                        rx_par_bit <= rx_sync;
                        rx_state   <= RX_STOP;
                    end else begin
                        rx_timer <= rx_timer + 1'b1;
                    end
                end

                RX_STOP: begin
                    if (rx_timer == BIT_LAST) begin
                        rx_timer      <= '0;
                        rx_data       <= rx_shift;
                        rx_valid      <= 1'b1;
                        rx_parity_err <= HAS_PARITY &&
                                         (rx_par_bit != ((^rx_shift) ^ ODD_PARITY));
                        rx_frame_err  <= !rx_sync;
                        // A high stop returns straight to IDLE, half a bit
                        // before the earliest next start edge. A low stop is
                        // a break: wait for the line to recover first.
                        rx_state      <= rx_sync ? RX_IDLE : RX_WAIT_HIGH;
                    end else begin
                        rx_timer <= rx_timer + 1'b1;
                    end
                end

                RX_WAIT_HIGH: begin
                    rx_timer <= '0;
                    if (rx_sync) begin
                        rx_state <= RX_IDLE;
                    end
                end

                default: begin
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_fd.md
Name: uart_fd

Overview:
Parametrised full-duplex UART, the successor to the fixed 8N1 half-duplex uart. It has independent TX and RX engines, so transmit and receive run at the same time. It adds configurable data width, parity and stop bits, mid-bit RX sampling with start-glitch rejection, and ready/valid handshakes. It sits between the board's serial pins and on-chip logic in icestick designs.

Parameters:
CLK_HZ, 12000000, system clock frequency in Hz
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide, 104 at defaults)
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, TX stop bits, legal 1..2; RX checks the first stop bit only

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active low
rx  in  1  serial input, asynchronous to clk
tx  out  1  serial output, idle high
tx_data  in  DATA_BITS  byte to send, sampled on handshake
tx_valid  in  1  transmit request
tx_ready  out  1  TX engine idle and able to accept
rx_data  out  DATA_BITS  last received payload
rx_valid  out  1  one-cycle pulse: new rx_data and error flags are valid
rx_parity_err  out  1  parity mismatch on the last frame
rx_frame_err  out  1  first stop bit sampled low on the last frame

Behaviour:
Reset
- One clock; reset is synchronous and active-low on rst_n.
- While rst_n=0 at an edge: tx=1, tx_ready=0, rx_valid=0, rx_data=0, both error flags 0, both FSMs IDLE, counters 0.
- tx_ready=1 on the first edge with rst_n=1.
- Reset mid-frame aborts the frame; tx is high after that edge and no rx_valid is issued.

Bit timer
- Per engine, width $clog2(CLKS_PER_BIT+1).
- Each bit lasts exactly CLKS_PER_BIT cycles.

TX FSM: IDLE -> START -> DATA -> PARITY (only if PARITY!=0) -> STOP -> IDLE
- Accept when tx_valid && tx_ready at an edge: latch tx_data, tx_ready=0 from that edge.
- Start bit (tx=0) is driven from the same edge, held CLKS_PER_BIT cycles.
- DATA: LSB first, DATA_BITS bits.
- Parity bit: even mode = XOR of data; odd mode = inverted XOR.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE with tx_ready=1.
- Frame length is (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
- tx_valid held high: the next accept occurs on the first IDLE cycle, giving one extra idle-high cycle between frames.
- tx_data changes after accept have no effect on the current frame.

RX path: two-flop synchroniser on rx; the FSM uses the synchronised value only.
RX FSM: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> (WAIT_HIGH) -> IDLE
- IDLE: synced rx low -> START, timer cleared.
- START: at CLKS_PER_BIT/2 re-sample.
  - High: treat as glitch, return to IDLE, no output.
  - Low: go to DATA, timer cleared.
- DATA/PARITY/STOP: sample at each CLKS_PER_BIT count, i.e. bit centre; shift LSB first.
- At the STOP sample edge:
  - rx_data <= payload, rx_valid=1 for one cycle.
  - rx_parity_err <= parity mismatch (0 when PARITY=0).
  - rx_frame_err <= (stop sample==0).
- Stop sampled high: go straight to IDLE; a start edge half a bit later is caught, so back-to-back frames are supported.
- Stop sampled low: WAIT_HIGH until synced rx=1, then IDLE (break handling).
- rx_data and the error flags hold until the next rx_valid.
- rx_valid has no backpressure; the consumer must take it in the pulse cycle.

Independence
- TX and RX share no state; simultaneous TX accept and RX completion are both honoured in the same cycle.

Test Plan:
1. Defaults, tx_data=0xA5, tx_valid for 1 cycle -> tx=0 for 104 cycles, then bits 1,0,1,0,0,1,0,1 at 104 cycles each, then high 104 cycles; tx_ready returns high 1040 cycles after accept.
2. tx looped to rx, tx_valid held high, frames 0x00, 0xFF, 0x55 -> three rx_valid pulses with matching rx_data; error flags 0; accepts spaced 1041 cycles.
3. PARITY=2, bench drives 0x07 with parity bit 0 (correct is 1) -> rx_valid, rx_data=0x07, rx_parity_err=1, rx_frame_err=0. Repeat with parity bit 1 -> rx_parity_err=0.
4. Bench drives 0x3C with stop bit low and rx held low 500 more cycles -> rx_valid with rx_frame_err=1; no further rx_valid until rx goes high and a new valid frame arrives.
5. rx pulsed low for 30 cycles -> no rx_valid; a valid 0x81 frame sent immediately after -> rx_data=0x81.
6. rst_n=0 during TX data bit 4, with RX mid-frame at the same time -> tx=1 at the next edge, tx_ready=0 until release then 1, no rx_valid; the next 0x5A loopback frame is received clean.
